// File: rtl/piso_flex.sv
// piso_flex -- parallel-in / serial-out width converter with valid/ready on
// both sides and per-word slice count.
//
// Ports:
//   CLK       clock, all state on rising edge
//   RST       synchronous active-high reset
//   IN_VLD    input word valid
//   IN_LAST   input word ends its packet
//   IN_DAT    parallel word [DATA_IN_WIDTH]
//   IN_NUM    valid slices in IN_DAT from the first-emitted end (0 = all)
//   IN_RDY    word accepted when IN_VLD && IN_RDY
//   OUT_DAT   serial slice [DATA_OUT_WIDTH]
//   OUT_VLD   slice valid
//   OUT_LAST  final slice of a packet
//   OUT_RDY   slice consumed when OUT_VLD && OUT_RDY
module piso_flex #(
  parameter  int DATA_IN_WIDTH  = 64,
  parameter  int DATA_OUT_WIDTH = 16,
  parameter  bit MSB_FIRST      = 0,
  localparam int NUM_SHIFTS     = DATA_IN_WIDTH / DATA_OUT_WIDTH,
  localparam int CNT_WIDTH      = $clog2(NUM_SHIFTS + 1)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      IN_VLD,
  input  logic                      IN_LAST,
  input  logic [DATA_IN_WIDTH-1:0]  IN_DAT,
  input  logic [CNT_WIDTH-1:0]      IN_NUM,
  output logic                      IN_RDY,
  output logic [DATA_OUT_WIDTH-1:0] OUT_DAT,
  output logic                      OUT_VLD,
  output logic                      OUT_LAST,
  input  logic                      OUT_RDY
);

  localparam logic [CNT_WIDTH-1:0] NS  = CNT_WIDTH'(NUM_SHIFTS);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [DATA_IN_WIDTH-1:0] sr;
  logic [CNT_WIDTH-1:0]     rem;
  logic                     last_q;
  logic [CNT_WIDTH-1:0]     n_eff;
  logic                     acc, xfer;

  // IN_NUM of 0 or beyond the word size means "the whole word".
  always_comb begin
    n_eff = IN_NUM;
    if (IN_NUM == '0 || IN_NUM > NS) n_eff = NS;
  end

  // Ready while empty, or while the final slice leaves this cycle, so that
  // back-to-back words stream without a bubble.
  assign IN_RDY   = !RST && ((rem == '0) || (rem == ONE && OUT_RDY));
  assign OUT_VLD  = (rem != '0);
  assign OUT_LAST = last_q && (rem == ONE);
  assign acc      = IN_VLD && IN_RDY;
  assign xfer     = OUT_VLD && OUT_RDY;

  // Emit end is the low slice for LSB-first, high slice for MSB-first;
  // the register shifts toward that end with zero fill.
  generate
    if (MSB_FIRST) begin : g_msb
      assign OUT_DAT = sr[DATA_IN_WIDTH-1 -: DATA_OUT_WIDTH];
    end else begin : g_lsb
      assign OUT_DAT = sr[DATA_OUT_WIDTH-1:0];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      sr     <= '0;
      rem    <= '0;
      last_q <= 1'b0;
    end else if (acc) begin
      // Reload wins over the concurrent final-slice transfer.
      sr     <= IN_DAT;
      rem    <= n_eff;
      last_q <= IN_LAST;
    end else if (xfer) begin
      sr  <= MSB_FIRST ? (sr << DATA_OUT_WIDTH) : (sr >> DATA_OUT_WIDTH);
      rem <= rem - ONE;
    end
  end

endmodule

// File: doc/piso_flex.md
PISO_FLEX -- requirements
Module: piso_flex

Interface
REQ-001 SHALL have parameter DATA_IN_WIDTH, default 64: width of the parallel input word.
REQ-002 SHALL have parameter DATA_OUT_WIDTH, default 16: width of each serial output slice.
REQ-003 SHALL have parameter MSB_FIRST, default 0: 0 = emit the low slice first, 1 = emit the high slice first.
REQ-004 SHALL define derived constants: NUM_SHIFTS = DATA_IN_WIDTH/DATA_OUT_WIDTH; CNT_WIDTH = clog2(NUM_SHIFTS+1).
REQ-005 SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port RST, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port IN_VLD, input, 1: input word valid.
REQ-008 SHALL have port IN_LAST, input, 1: input word is the last of its packet.
REQ-009 SHALL have port IN_DAT, input, DATA_IN_WIDTH: parallel input word.
REQ-010 SHALL have port IN_NUM, input, CNT_WIDTH: number of valid slices in IN_DAT, counted from the first-emitted end.
REQ-011 SHALL have port IN_RDY, output, 1: block accepts an input word.
REQ-012 SHALL have port OUT_DAT, output, DATA_OUT_WIDTH: serial slice.
REQ-013 SHALL have port OUT_VLD, output, 1: slice valid.
REQ-014 SHALL have port OUT_LAST, output, 1: slice is the final slice of a packet.
REQ-015 SHALL have port OUT_RDY, input, 1: downstream accepts the slice.

Function
REQ-016 SHALL support only DATA_IN_WIDTH an integer multiple of DATA_OUT_WIDTH with NUM_SHIFTS >= 1; NUM_SHIFTS = 1 degenerates to a one-entry registered stage.
REQ-017 SHALL accept an input word on a cycle where IN_VLD and IN_RDY are both high; SHALL transfer a slice on a cycle where OUT_VLD and OUT_RDY are both high.
REQ-018 SHALL hold an internal shift register (DATA_IN_WIDTH), a remaining-slice counter REM (CNT_WIDTH) and a last flag; OUT_VLD = (REM != 0).
REQ-019 SHALL compute the effective count N from IN_NUM: IN_NUM = 0 gives N = NUM_SHIFTS; IN_NUM > NUM_SHIFTS is clamped to N = NUM_SHIFTS; otherwise N = IN_NUM.
REQ-020 SHALL drive IN_RDY = (REM == 0) or (REM == 1 and OUT_RDY), combinationally, so consecutive words stream with no bubble.
REQ-021 SHALL, on accept, load the shift register with IN_DAT, set REM = N and capture IN_LAST; the first slice appears on OUT_DAT the next cycle (1-cycle latency, no bypass path).
REQ-022 SHALL, on a slice transfer without a simultaneous accept, shift the register by DATA_OUT_WIDTH toward the emit end, zero-filled, and decrement REM.
REQ-023 SHALL let an accept on the same cycle as the final slice transfer take priority: reload as in REQ-021 with no idle cycle.
REQ-024 SHALL drive OUT_DAT from the low slice of the shift register when MSB_FIRST = 0 and from the high slice when MSB_FIRST = 1; slices beyond N are never presented.
REQ-025 SHALL drive OUT_LAST = last flag and (REM == 1); OUT_LAST SHALL never be asserted while OUT_VLD is low.
REQ-026 SHALL hold OUT_DAT, OUT_VLD and OUT_LAST stable while OUT_VLD is high and OUT_RDY is low.
REQ-027 SHALL ignore IN_DAT, IN_NUM and IN_LAST on cycles without an accept.

Reset
REQ-028 SHALL, while RST is high at a clock edge, clear REM, the shift register and the last flag; the next cycle OUT_VLD = 0, OUT_LAST = 0 and OUT_DAT = 0.
REQ-029 SHALL force IN_RDY = 0 while RST is high; any in-flight word is discarded, and no partial slice is emitted after reset deasserts.

Verification
REQ-030 Defaults, OUT_RDY = 1, IN_DAT = 0x4444_3333_2222_1111, IN_NUM = 4, IN_LAST = 0 -> OUT_DAT = 0x1111, 0x2222, 0x3333, 0x4444 on cycles 1-4; a second word accepted on cycle 4 yields its first slice on cycle 5, with no gap.
REQ-031 MSB_FIRST = 1, same word -> 0x4444, 0x3333, 0x2222, 0x1111.
REQ-032 IN_NUM = 2, IN_LAST = 1 -> exactly 0x1111, 0x2222, with OUT_LAST high only on 0x2222; IN_NUM = 0 -> 4 slices; IN_NUM = 7 -> 4 slices.
REQ-033 OUT_RDY low for 3 cycles during slice 2 -> 0x2222 is held stable with OUT_VLD = 1 and IN_RDY = 0; the sequence resumes with no loss or duplication.
REQ-034 RST asserted for 1 cycle after slice 2 -> OUT_VLD = 0 the next cycle; a new word with IN_NUM = 1 then yields a single slice with the correct data.
REQ-035 Random valid/ready (both sides), random IN_NUM, NUM_SHIFTS in {1, 2, 4} -> the scoreboard matches the slice sequence and OUT_LAST positions exactly.
